// File: rtl/reg_file_mp.sv
// Multi-port register file: three combinational reads, two writes (ALU + load),
// optional write-to-read bypass, per-register load scoreboard and sticky conflict flag.
module reg_file_mp #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned PC_INDEX = 15,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] ra3,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  output logic [WIDTH-1:0]  rd3,
  input  logic              we3,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [WIDTH-1:0]  wd3,
  input  logic              we4,
  input  logic [ADDR_W-1:0] wa4,
  input  logic [WIDTH-1:0]  wd4,
  input  logic [WIDTH-1:0]  r15,
  input  logic              claim,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic              busy1,
  output logic              busy2,
  output logic              busy3,
  output logic              wr_conflict
);

  localparam int unsigned       DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_A  = ADDR_W'(PC_INDEX);

  logic [WIDTH-1:0]  regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic              conflict_q, conflict_d;
  logic              wr3, wr4, collide;

  logic [ADDR_W-1:0] ra  [3];
  logic [WIDTH-1:0]  rd  [3];
  logic [2:0]        bz;

  // Port 3 wins a same-address collision, so port 4 is suppressed there.
  assign wr3     = we3 && (wa3 != PC_A);
  assign collide = wr3 && we4 && (wa4 == wa3);
  assign wr4     = we4 && (wa4 != PC_A) && !collide;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      if (wr3) regs_q[wa3] <= wd3;
      if (wr4) regs_q[wa4] <= wd4;
    end
  end

  // A claim applied after the release makes a same-cycle re-claim win.
  always_comb begin
    busy_d = busy_q;
    if (we4 && (wa4 != PC_A))          busy_d[wa4]        = 1'b0;
    if (claim && (claim_addr != PC_A)) busy_d[claim_addr] = 1'b1;
    conflict_d = conflict_q | collide;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign ra[0] = ra1;
  assign ra[1] = ra2;
  assign ra[2] = ra3;

  // Priority lowest to highest: stored, load bypass, ALU bypass, PC alias.
  always_comb begin
    for (int unsigned p = 0; p < 3; p++) begin
      rd[p] = regs_q[ra[p]];
      bz[p] = busy_q[ra[p]];
      if (BYPASS != 0) begin
        if (we4 && (wa4 == ra[p])) begin
          rd[p] = wd4;
          bz[p] = 1'b0;
        end
        if (we3 && (wa3 == ra[p])) rd[p] = wd3;
      end
      if (ra[p] == PC_A) begin
        rd[p] = r15;
        bz[p] = 1'b0;
      end
    end
  end

  assign rd1         = rd[0];
  assign rd2         = rd[1];
  assign rd3         = rd[2];
  assign busy1       = bz[0];
  assign busy2       = bz[1];
  assign busy3       = bz[2];
  assign wr_conflict = conflict_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a BYPASS=1 and a BYPASS=0 instance share all inputs.
module tb_reg_file_mp;

  logic        clk, reset;
  logic [3:0]  ra1, ra2, ra3, wa3, wa4, claim_addr;
  logic [31:0] wd3, wd4, r15;
  logic        we3, we4, claim;

  logic [31:0] b_rd1, b_rd2, b_rd3, n_rd1, n_rd2, n_rd3;
  logic        b_busy1, b_busy2, b_busy3, b_conf;
  logic        n_busy1, n_busy2, n_busy3, n_conf;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  reg_file_mp #(.WIDTH(32), .ADDR_W(4), .PC_INDEX(15), .BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .ra3(ra3),
    .rd1(b_rd1), .rd2(b_rd2), .rd3(b_rd3),
    .we3(we3), .wa3(wa3), .wd3(wd3), .we4(we4), .wa4(wa4), .wd4(wd4),
    .r15(r15), .claim(claim), .claim_addr(claim_addr),
    .busy1(b_busy1), .busy2(b_busy2), .busy3(b_busy3), .wr_conflict(b_conf)
  );

  reg_file_mp #(.WIDTH(32), .ADDR_W(4), .PC_INDEX(15), .BYPASS(0)) u_nob (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .ra3(ra3),
    .rd1(n_rd1), .rd2(n_rd2), .rd3(n_rd3),
    .we3(we3), .wa3(wa3), .wd3(wd3), .we4(we4), .wa4(wa4), .wd4(wd4),
    .r15(r15), .claim(claim), .claim_addr(claim_addr),
    .busy1(n_busy1), .busy2(n_busy2), .busy3(n_busy3), .wr_conflict(n_conf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed and checked mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_writes();
    we3 = 1'b0; we4 = 1'b0; claim = 1'b0;
  endtask

  initial begin
    #5000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    ra1 = 4'd3; ra2 = 4'd15; ra3 = 4'd0;
    wa3 = 4'd0; wa4 = 4'd0; claim_addr = 4'd0;
    wd3 = '0; wd4 = '0; r15 = 32'h0000_0108;
    idle_writes();
    #2;
    check("rst_rd1",  b_rd1, 32'h0);
    check("rst_rd2",  b_rd2, 32'h108);
    check("rst_nrd2", n_rd2, 32'h108);
    check("rst_busy1", {31'b0, b_busy1}, 32'h0);
    check("rst_busy2", {31'b0, b_busy2}, 32'h0);
    check("rst_conf", {31'b0, b_conf}, 32'h0);
    step();
    reset = 1'b0;

    // ALU write to r2
    step();
    we3 = 1'b1; wa3 = 4'd2; wd3 = 32'hDEADBEEF; ra1 = 4'd2;
    #1;
    check("wr_byp_same",  b_rd1, 32'hDEADBEEF);
    check("wr_nob_same",  n_rd1, 32'h0);
    step();
    idle_writes();
    #1;
    check("wr_byp_next",  b_rd1, 32'hDEADBEEF);
    check("wr_nob_next",  n_rd1, 32'hDEADBEEF);

    // Load claim of r5
    claim = 1'b1; claim_addr = 4'd5; ra1 = 4'd5; ra3 = 4'd5;
    #1;
    check("claim_same_busy1", {31'b0, b_busy1}, 32'h0);
    step();
    idle_writes();
    #1;
    check("claim_busy1",   {31'b0, b_busy1}, 32'h1);
    check("claim_busy3",   {31'b0, b_busy3}, 32'h1);
    check("claim_nbusy1",  {31'b0, n_busy1}, 32'h1);

    // Load writeback releases r5
    we4 = 1'b1; wa4 = 4'd5; wd4 = 32'h1234;
    #1;
    check("ld_byp_busy1", {31'b0, b_busy1}, 32'h0);
    check("ld_byp_rd1",   b_rd1, 32'h1234);
    check("ld_byp_rd3",   b_rd3, 32'h1234);
    check("ld_nob_busy1", {31'b0, n_busy1}, 32'h1);
    check("ld_nob_rd1",   n_rd1, 32'h0);
    step();
    idle_writes();
    #1;
    check("ld_nob_busy_next", {31'b0, n_busy1}, 32'h0);
    check("ld_nob_rd_next",   n_rd1, 32'h1234);
    check("ld_byp_busy_next", {31'b0, b_busy1}, 32'h0);

    // Re-claim and release of r5 in the same cycle: claim wins
    claim = 1'b1; claim_addr = 4'd5; we4 = 1'b1; wa4 = 4'd5; wd4 = 32'h55;
    step();
    idle_writes();
    #1;
    check("reclaim_busy1",  {31'b0, b_busy1}, 32'h1);
    check("reclaim_nbusy1", {31'b0, n_busy1}, 32'h1);
    check("reclaim_rd1",    n_rd1, 32'h55);

    // Same-address collision on r7
    we3 = 1'b1; we4 = 1'b1; wa3 = 4'd7; wa4 = 4'd7; wd3 = 32'hA; wd4 = 32'hB; ra1 = 4'd7;
    #1;
    check("col_byp_same", b_rd1, 32'hA);
    check("col_conf_pre", {31'b0, b_conf}, 32'h0);
    step();
    idle_writes();
    #1;
    check("col_rd1",  b_rd1, 32'hA);
    check("col_nrd1", n_rd1, 32'hA);
    for (int i = 0; i < 10; i++) begin
      check("col_conf_hold",  {31'b0, b_conf}, 32'h1);
      check("col_nconf_hold", {31'b0, n_conf}, 32'h1);
      step();
    end

    // Busy on r4, then an asynchronous reset in mid-cycle
    claim = 1'b1; claim_addr = 4'd4; ra2 = 4'd4; ra1 = 4'd2;
    step();
    idle_writes();
    #1;
    check("pre_rst_busy2", {31'b0, b_busy2}, 32'h1);
    check("pre_rst_rd1",   b_rd1, 32'hDEADBEEF);
    #1;
    reset = 1'b1;
    #1;
    check("arst_rd1",   b_rd1, 32'h0);
    check("arst_nrd1",  n_rd1, 32'h0);
    check("arst_busy2", {31'b0, b_busy2}, 32'h0);
    check("arst_conf",  {31'b0, b_conf}, 32'h0);
    #1;
    reset = 1'b0;
    step();
    #1;
    check("post_rst_busy2", {31'b0, n_busy2}, 32'h0);
    check("post_rst_rd2",   n_rd2, 32'h0);

    // Writes and claim aimed at the PC alias are ignored
    r15 = 32'h0000_0200; ra1 = 4'd15; ra3 = 4'd15;
    we3 = 1'b1; wa3 = 4'd15; wd3 = 32'hFFFF;
    we4 = 1'b1; wa4 = 4'd15; wd4 = 32'hFFFF;
    claim = 1'b1; claim_addr = 4'd15;
    #1;
    check("pc_byp_rd1",   b_rd1, 32'h200);
    check("pc_byp_busy1", {31'b0, b_busy1}, 32'h0);
    step();
    idle_writes();
    #1;
    check("pc_rd1",    b_rd1, 32'h200);
    check("pc_nrd3",   n_rd3, 32'h200);
    check("pc_nbusy1", {31'b0, n_busy1}, 32'h0);
    check("pc_conf",   {31'b0, b_conf}, 32'h0);
    check("pc_nconf",  {31'b0, n_conf}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
